// File: rtl/mips_program_loader.sv
// Streams big-endian program bytes into instruction memory,
// holding the MIPS core stalled until the end marker or a full memory.
module mips_program_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] END_WORD = 32'hFFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [ADDR_WIDTH:0]   word_count
);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] addr;
  logic [1:0]            byte_idx;
  logic [DATA_WIDTH-1:0] word;
  logic [ADDR_WIDTH:0]   wcnt;
  logic                  ovf;
  logic                  is_end;
  logic                  addr_last;

  assign is_end     = (word == END_WORD);
  assign addr_last  = &addr;
  assign imem_addr  = addr;
  assign imem_wdata = word;
  assign word_count = wcnt;
  assign overflow   = ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) state_nx = RECV;
      end
      RECV: begin
        if (rx_valid && byte_idx == 2'd3) state_nx = WRITE;
      end
      WRITE: begin
        if (is_end || addr_last) state_nx = DONE;
        else                     state_nx = RECV;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rx_ready = (state == RECV);
    busy     = (state == RECV) || (state == WRITE);
    cpu_hold = busy;
    imem_we  = (state == WRITE) && !is_end;
    done     = (state == DONE);
  end

  // Datapath: byte assembly, write address and load statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr     <= '0;
      byte_idx <= '0;
      word     <= '0;
      wcnt     <= '0;
      ovf      <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            addr     <= '0;
            byte_idx <= '0;
            word     <= '0;
            wcnt     <= '0;
            ovf      <= 1'b0;
          end
        end
        RECV: begin
          if (rx_valid) begin
            word     <= {word[DATA_WIDTH-9:0], rx_data};
            byte_idx <= byte_idx + 2'd1;
          end
        end
        WRITE: begin
          if (!is_end) begin
            addr <= addr + ADDR_WIDTH'(1);
            wcnt <= wcnt + (ADDR_WIDTH+1)'(1);
            if (addr_last) ovf <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_program_loader.sv
// Randomized bench for mips_program_loader against a
// word-list reference model of the loaded program.
module tb_mips_program_loader;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [AW:0]   word_count;

  mips_program_loader #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(AW),
    .END_WORD(32'hFFFF_FFFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold),
    .busy(busy),
    .done(done),
    .overflow(overflow),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0]  prog[$];
  logic [31:0] exp_d[$];
  int          exp_used;
  bit          exp_of;
  int          wa[$];
  logic [31:0] wd[$];

  always @(negedge clk) begin
    if (imem_we) begin
      wa.push_back(int'(imem_addr));
      wd.push_back(imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {21'd0, rx_ready, imem_we, imem_addr, imem_wdata,
            cpu_hold, busy, done, overflow, word_count};
  endfunction

  // Expected writes: successive big-endian words up to the marker
  // or until memory is full.
  task automatic model_run();
    logic [31:0] w;
    exp_d.delete();
    exp_of   = 0;
    exp_used = 0;
    for (int i = 0; i + 3 < prog.size(); i += 4) begin
      w = {prog[i], prog[i+1], prog[i+2], prog[i+3]};
      exp_used = i + 4;
      if (w == 32'hFFFF_FFFF) break;
      exp_d.push_back(w);
      if (exp_d.size() == DEPTH) begin
        exp_of = 1;
        break;
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap,
                           input int limit, output bit ok);
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (rx_ready) ok = 1;
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic load(input int maxgap, input int start_at,
                      input bit do_start);
    bit ok;
    wa.delete();
    wd.delete();
    model_run();
    if (do_start) pulse_start();
    for (int i = 0; i < exp_used; i++) begin
      if (i == start_at) pulse_start();
      send_byte(prog[i], $urandom_range(maxgap, 0), 40, ok);
      check("byte_accept", 64'(ok), 64'd1);
    end
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1;
      @(posedge clk);
      #1;
    end
    check("done", 64'(ok), 64'd1);
    check("word_count", 64'(word_count), 64'(exp_d.size()));
    check("overflow", 64'(overflow), 64'(exp_of));
    check("idle_flags", {60'd0, busy, cpu_hold, rx_ready, imem_we}, 64'd0);
    check("n_writes", 64'(wd.size()), 64'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < wd.size(); i++) begin
      check("waddr", 64'(wa[i]), 64'(i));
      check("wdata", 64'(wd[i]), 64'(exp_d[i]));
    end
    if (exp_of && exp_used < prog.size()) begin
      send_byte(prog[exp_used], 0, 6, ok);
      check("ovf_reject", 64'(ok), 64'd0);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) prog.push_back(w[8*k +: 8]);
  endtask

  task automatic basic_prog();
    prog.delete();
    push_word(32'h2001_0005);
    push_word(32'h2002_000A);
    push_word(32'h0022_1820);
    push_word(32'hFFFF_FFFF);
  endtask

  initial begin
    bit ok;
    logic [31:0] w;
    int n;
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", all_outs(), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("idle_outs", all_outs(), 64'd0);

    basic_prog();
    load(0, -1, 1);
    basic_prog();
    load(5, -1, 1);

    prog.delete();
    for (int i = 1; i <= 5; i++) push_word(32'(i));
    load(2, -1, 1);

    // Reset after two bytes of a word.
    pulse_start();
    send_byte(8'h12, 0, 10, ok);
    check("rst_b0", 64'(ok), 64'd1);
    send_byte(8'h34, 1, 10, ok);
    check("rst_b1", 64'(ok), 64'd1);
    reset = 1'b1;
    #1;
    check("async_reset", all_outs(), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_idle", all_outs(), 64'd0);
    prog.delete();
    push_word(32'hAABB_CCDD);
    push_word(32'hFFFF_FFFF);
    load(1, -1, 1);

    basic_prog();
    load(1, 2, 1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("restart_done", 64'(done), 64'd0);
    check("restart_busy", 64'(busy), 64'd1);
    prog.delete();
    push_word(32'h1122_3344);
    push_word(32'hFFFF_FFFF);
    load(0, -1, 0);

    prog.delete();
    push_word(32'hFFFF_FFFF);
    load(0, -1, 1);

    for (int t = 0; t < 20; t++) begin
      prog.delete();
      n = $urandom_range(5, 0);
      for (int i = 0; i < n; i++) begin
        w = $urandom();
        if (w == 32'hFFFF_FFFF) w = 32'h0;
        push_word(w);
      end
      push_word(32'hFFFF_FFFF);
      push_word($urandom());
      load($urandom_range(3, 0), -1, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_program_loader.md
Name: mips_program_loader

Overview:
- Loads a program into the pipeline's instruction memory from an external byte stream, then releases the core.
- Sits between the host-side receive path (UART RX or testbench driver) and the instruction-memory write port.
- Holds the MIPS core stalled while loading.
- A loaded program is later checked by the pipeline testbenches through register-file and data-memory state.

Parameters:
- DATA_WIDTH, 32, instruction word width. The byte-assembly logic supports only 32.
- ADDR_WIDTH, 8, instruction-memory word-address width. Depth is 2^ADDR_WIDTH words.
- END_WORD, 32'hFFFF_FFFF, end-of-program marker. It is never written to memory.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a load
- rx_data  in  8  incoming program byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts a byte this cycle
- imem_we  out  1  instruction-memory write enable, one cycle per word
- imem_addr  out  ADDR_WIDTH  word address for the write
- imem_wdata  out  DATA_WIDTH  assembled instruction word
- cpu_hold  out  1  stall/hold for the MIPS core while loading
- busy  out  1  load in progress
- done  out  1  load finished; held until next start or reset
- overflow  out  1  load ended because memory was full
- word_count  out  ADDR_WIDTH+1  number of words written in the current/last load

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - All outputs go to 0, including imem_addr, imem_wdata and word_count.
  - Byte index and assembly register are cleared.
  - Instruction-memory contents are not touched.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - Outputs rx_ready=0, cpu_hold=0, busy=0.
  - start=1 goes to RECV.
  - On entry to RECV: addr=0, byte_idx=0, word_count=0, overflow=0, done=0.
- RECV:
  - rx_ready=1, busy=1, cpu_hold=1.
  - A byte transfers on a rising edge where rx_valid && rx_ready.
  - Byte order is big-endian: first byte goes to bits [31:24], the fourth byte to [7:0]. Shifting is word = {word[23:0], rx_data}.
  - byte_idx is 2 bits. On the edge accepting the 4th byte, byte_idx wraps to 0 and state goes to WRITE.
  - rx_valid=0 leaves state unchanged; idle gaps of any length are allowed.
- WRITE (exactly one cycle):
  - rx_ready=0; a presented byte must be held by the source.
  - busy=1, cpu_hold=1.
  - If word == END_WORD: imem_we=0, go to DONE, overflow stays 0.
  - Otherwise:
    - imem_we=1 with imem_addr=addr and imem_wdata=word.
    - On the edge: addr increments and word_count increments.
    - If addr was 2^ADDR_WIDTH-1 before the increment: go to DONE with overflow=1.
    - Otherwise return to RECV.
- Latency: the 4th byte is accepted at edge k; imem_we is high for the cycle between edges k and k+1. The next byte can be accepted no earlier than edge k+2.
- DONE:
  - done=1, busy=0, cpu_hold=0, rx_ready=0.
  - word_count and overflow hold their values.
  - start=1 restarts into RECV with the same clearing as from IDLE; done drops on the next edge.
- start while in RECV or WRITE is ignored.
- A partial word (1-3 bytes) is never written.
- Reset mid-load aborts the load. Words already written remain in memory; the next load overwrites from address 0.
- The imem_addr register wraps to 0 after overflow. This is don't-care because imem_we is 0 outside WRITE.

Test Plan:
1. Normal load:
   - start, then bytes 20 01 00 05 | 20 02 00 0A | 00 22 18 20 | FF FF FF FF.
   - Required: writes addr0=0x20010005, addr1=0x2002000A, addr2=0x00221820; no 4th write.
   - Required: done=1, word_count=3, overflow=0, cpu_hold falls with done.
2. Back-pressure and gaps:
   - Same stream as scenario 1 with random 0-5 cycle rx_valid gaps.
   - A byte is presented during WRITE and held until rx_ready=1.
   - Required: identical memory contents to scenario 1; no byte lost or duplicated.
3. Overflow (ADDR_WIDTH=2):
   - Send 5 non-marker words, 0x00000001..0x00000005.
   - Required: writes only to addr0..3 with values 1..4; done=1, overflow=1, word_count=4.
   - Required: rx_ready=0 thereafter, so the 5th word's bytes are not accepted.
4. Reset mid-word:
   - After 2 bytes of a word, assert reset for 1 cycle.
   - Required: all outputs are 0 immediately (asynchronous) and state is IDLE.
   - Then start and send AA BB CC DD FF FF FF FF. Required: addr0=0xAABBCCDD, word_count=1.
5. Start handling:
   - Pulse start during RECV. Required: no effect.
   - Pulse start in DONE. Required: done=0 next cycle, busy=1, first new word written at addr0.
6. Empty program:
   - start, then FF FF FF FF only.
   - Required: no imem_we pulse, done=1, word_count=0, overflow=0.
